// File: rtl/hazard_interlock_if.sv
// Handshake bundle between the SimpleRISC pipeline front-end and the hazard interlock.
// The pipeline (master) presents the OF instruction and branch resolution; the interlock
// (slave) returns stall/bubble/flush, forwarding selects and its event counters.
interface hazard_interlock_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  of_valid;
    logic [REG_ADDR_W-1:0] of_rs1;
    logic [REG_ADDR_W-1:0] of_rs2;
    logic                  of_rs1_used;
    logic                  of_rs2_used;
    logic [REG_ADDR_W-1:0] of_rd;
    logic                  of_isWb;
    logic                  of_isLd;
    logic                  branch_taken;

    logic                  stall;
    logic                  bubble;
    logic                  flush;
    logic [2:0]            fwd_sel1;
    logic [2:0]            fwd_sel2;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output of_valid, of_rs1, of_rs2, of_rs1_used, of_rs2_used, of_rd, of_isWb, of_isLd,
        output branch_taken,
        input  stall, bubble, flush, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

    modport slave (
        input  of_valid, of_rs1, of_rs2, of_rs1_used, of_rs2_used, of_rd, of_isWb, of_isLd,
        input  branch_taken,
        output stall, bubble, flush, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_interlock.sv
// Read-after-write hazard controller for the in-order SimpleRISC pipeline.
// Tracks every instruction past OF in a small scoreboard, then either stalls IF/OF
// (inserting a bubble) or picks a forwarding source for each OF operand. A taken branch
// flushes IF/OF and takes priority over any hazard. Stall/flush events are counted.
module hazard_interlock #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned WB_BYPASS  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_interlock_if.slave bus
);
    // Youngest-to-oldest stages that can still hurt the OF read; a bypassing register file
    // makes the WB stage harmless.
    localparam int unsigned ChkLast = STAGES - WB_BYPASS;

    logic [STAGES:1]       v_q, v_d;
    logic [STAGES:1]       wb_q, wb_d;
    logic [STAGES:1]       ld_q, ld_d;
    logic [REG_ADDR_W-1:0] rd_q [1:STAGES];
    logic [REG_ADDR_W-1:0] rd_d [1:STAGES];

    logic [STAGES:1]       hit1, hit2;
    logic [2:0]            sel1, sel2;
    logic                  raw_stall;
    logic                  stall;
    logic                  flush;
    logic                  issue;

    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    // Match each OF source against every in-flight producer in the checked range.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int unsigned k = 1; k <= STAGES; k++) begin
            if (k <= ChkLast) begin
                hit1[k] = bus.of_valid & bus.of_rs1_used & v_q[k] & wb_q[k]
                        & (rd_q[k] == bus.of_rs1);
                hit2[k] = bus.of_valid & bus.of_rs2_used & v_q[k] & wb_q[k]
                        & (rd_q[k] == bus.of_rs2);
            end
        end
    end

    // Youngest producer wins: scan oldest first so the smallest matching stage is kept.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int unsigned k = STAGES; k >= 1; k--) begin
            if (hit1[k]) sel1 = 3'(k);
            if (hit2[k]) sel2 = 3'(k);
        end
    end

    // Hazard decision; a taken branch overrides any stall and reset masks every output.
    always_comb begin
        if (FWD_EN != 0) begin
            // Only a load in ALU cannot be forwarded yet.
            raw_stall = (hit1[1] | hit2[1]) & ld_q[1];
        end else begin
            raw_stall = (|hit1) | (|hit2);
        end
        flush        = bus.branch_taken & ~rst;
        stall        = raw_stall & ~bus.branch_taken & ~rst;
        issue        = bus.of_valid & ~stall & ~flush;
        bus.stall    = stall;
        bus.bubble   = stall | flush;
        bus.flush    = flush;
        bus.fwd_sel1 = ((FWD_EN != 0) && !stall && !rst) ? sel1 : 3'd0;
        bus.fwd_sel2 = ((FWD_EN != 0) && !stall && !rst) ? sel2 : 3'd0;
    end

    // Scoreboard next state: new entry (or bubble) at stage 1, all others age by one.
    always_comb begin
        v_d[1]  = issue;
        wb_d[1] = issue & bus.of_isWb;
        ld_d[1] = issue & bus.of_isLd;
        rd_d[1] = issue ? bus.of_rd : '0;
        for (int unsigned k = 2; k <= STAGES; k++) begin
            v_d[k]  = v_q[k-1];
            wb_d[k] = wb_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d   = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d   = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            wb_q        <= '0;
            ld_q        <= '0;
            for (int unsigned k = 1; k <= STAGES; k++) begin
                rd_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            wb_q        <= wb_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_interlock.sv
// Bench for hazard_interlock: three configurations share one stimulus stream
// (A: forwarding, B: full interlock with WB bypass, C: full interlock, no bypass, 4-bit
// counters). Expected outputs come from an issue-history model: each issued instruction is
// stamped with its issue cycle, so its stage is simply its age in cycles.
`define HI_DRIVE(B) \
    B.of_valid = cur_valid; B.of_rs1 = cur_rs1; B.of_rs2 = cur_rs2; \
    B.of_rs1_used = cur_u1; B.of_rs2_used = cur_u2; B.of_rd = cur_rd; \
    B.of_isWb = cur_wb; B.of_isLd = cur_ld; B.branch_taken = cur_br;

`define HI_OBS(D, B) \
    ob[D][0] = 32'(B.stall); ob[D][1] = 32'(B.bubble); ob[D][2] = 32'(B.flush); \
    ob[D][3] = 32'(B.fwd_sel1); ob[D][4] = 32'(B.fwd_sel2); \
    ob[D][5] = 32'(B.stall_cnt); ob[D][6] = 32'(B.flush_cnt);

module tb_hazard_interlock;
    localparam int unsigned RW  = 5;
    localparam int          STG = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_interlock_if #(.REG_ADDR_W(RW), .CNT_W(16)) bus_a ();
    hazard_interlock_if #(.REG_ADDR_W(RW), .CNT_W(16)) bus_b ();
    hazard_interlock_if #(.REG_ADDR_W(RW), .CNT_W(4))  bus_c ();

    hazard_interlock #(.REG_ADDR_W(RW), .STAGES(STG), .FWD_EN(1), .WB_BYPASS(1), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    hazard_interlock #(.REG_ADDR_W(RW), .STAGES(STG), .FWD_EN(0), .WB_BYPASS(1), .CNT_W(16))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    hazard_interlock #(.REG_ADDR_W(RW), .STAGES(STG), .FWD_EN(0), .WB_BYPASS(0), .CNT_W(4))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Current OF inputs, mirrored for the model.
    bit       cur_valid, cur_u1, cur_u2, cur_wb, cur_ld, cur_br;
    bit [4:0] cur_rs1, cur_rs2, cur_rd;

    // Observed outputs per DUT: stall, bubble, flush, fwd1, fwd2, stall_cnt, flush_cnt.
    logic [31:0] ob [3][7];
    always_comb begin
        `HI_OBS(0, bus_a)
        `HI_OBS(1, bus_b)
        `HI_OBS(2, bus_c)
    end

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int exp_sc [3];
    int exp_fc [3];

    typedef struct {
        int       d;
        int       t;
        bit       wb;
        bit       ld;
        bit [4:0] rd;
    } rec_t;
    rec_t recs [$];

    function automatic int fwd_of(int d);  return (d == 0) ? 1 : 0;      endfunction
    function automatic int byp_of(int d);  return (d == 2) ? 0 : 1;      endfunction
    function automatic int max_of(int d);  return (d == 2) ? 15 : 65535; endfunction

    // Age in cycles of the youngest issued writer of rs still visible to DUT d (0 = none).
    function automatic int youngest(int d, bit [4:0] rs, bit used, output bit ld);
        int best;
        int age;
        best = 0;
        ld   = 1'b0;
        if (cur_valid && used) begin
            foreach (recs[i]) begin
                age = cyc - recs[i].t;
                if (recs[i].d == d && age >= 1 && age <= STG - byp_of(d) && recs[i].wb &&
                    recs[i].rd == rs && (best == 0 || age < best)) begin
                    best = age;
                    ld   = recs[i].ld;
                end
            end
        end
        return best;
    endfunction

    task automatic model_expect(input int d, output bit st, output bit fl,
                                output int f1, output int f2);
        bit ld1, ld2;
        int y1, y2;
        y1 = youngest(d, cur_rs1, cur_u1, ld1);
        y2 = youngest(d, cur_rs2, cur_u2, ld2);
        fl = cur_br;
        if (cur_br)          st = 1'b0;
        else if (fwd_of(d))  st = (y1 == 1 && ld1) || (y2 == 1 && ld2);
        else                 st = (y1 != 0) || (y2 != 0);
        f1 = (fwd_of(d) != 0 && !st) ? y1 : 0;
        f2 = (fwd_of(d) != 0 && !st) ? y2 : 0;
    endtask

    task automatic check(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                         input bit u2, input bit [4:0] rd, input bit wb, input bit ld,
                         input bit br);
        cur_valid = v;  cur_rs1 = r1; cur_u1 = u1; cur_rs2 = r2; cur_u2 = u2;
        cur_rd    = rd; cur_wb  = wb; cur_ld = ld; cur_br  = br;
        `HI_DRIVE(bus_a)
        `HI_DRIVE(bus_b)
        `HI_DRIVE(bus_c)
    endtask

    task automatic check_model();
        bit st, fl;
        int f1, f2;
        for (int d = 0; d < 3; d++) begin
            model_expect(d, st, fl, f1, f2);
            check("stall",     d, ob[d][0], 32'(st));
            check("bubble",    d, ob[d][1], 32'(st | fl));
            check("flush",     d, ob[d][2], 32'(fl));
            check("fwd_sel1",  d, ob[d][3], 32'(f1));
            check("fwd_sel2",  d, ob[d][4], 32'(f2));
            check("stall_cnt", d, ob[d][5], 32'(exp_sc[d]));
            check("flush_cnt", d, ob[d][6], 32'(exp_fc[d]));
        end
    endtask

    task automatic advance();
        bit st, fl;
        int f1, f2;
        for (int d = 0; d < 3; d++) begin
            model_expect(d, st, fl, f1, f2);
            if (st && exp_sc[d] < max_of(d)) exp_sc[d]++;
            if (fl && exp_fc[d] < max_of(d)) exp_fc[d]++;
            if (cur_valid && !st && !fl)
                recs.push_back('{d: d, t: cyc, wb: cur_wb, ld: cur_ld, rd: cur_rd});
        end
        while (recs.size() > 0 && cyc - recs[0].t >= STG) void'(recs.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic nops(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic model_reset();
        recs.delete();
        for (int d = 0; d < 3; d++) begin
            exp_sc[d] = 0;
            exp_fc[d] = 0;
        end
    endtask

    task automatic check_reset();
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 7; w++) check("rst_out", d, ob[d][w], 32'd0);
    endtask

    // Mid-cycle asynchronous reset pulse spanning one rising edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int bexp [4];
        int cexp [4];
        bexp = '{1, 1, 0, 0};
        cexp = '{1, 1, 1, 0};
        model_reset();
        drive(1, 3, 1, 3, 1, 3, 1, 1, 1);
        #1 rst = 1'b1;
        #2 check_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset: load flush_cnt and e[1], then reset asynchronously mid-cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        drive(1, 3, 1, 1, 0, 4, 1, 0, 0);
        async_reset();
        @(negedge clk);
        check_model();
        check("post_rst_stall", 1, ob[1][0], 0);
        advance();
        nops(4);

        // Forwarding from ALU, then from DM with an independent instruction between.
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0);
        @(negedge clk);
        check_model();
        check("adj_stall", 0, ob[0][0], 0);
        check("adj_fwd1",  0, ob[0][3], 1);
        check("adj_fwd2",  0, ob[0][4], 0);
        advance();
        nops(4);
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
        cycle();
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0);
        @(negedge clk);
        check_model();
        check("gap_fwd1", 0, ob[0][3], 2);
        advance();
        nops(4);

        // Load-use: one stall, then forward from DM; no stall if the source is unused.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        cycle();
        drive(1, 1, 1, 5, 1, 6, 1, 0, 0);
        @(negedge clk);
        check_model();
        check("lu_stall",  0, ob[0][0], 1);
        check("lu_bubble", 0, ob[0][1], 1);
        advance();
        @(negedge clk);
        check_model();
        check("lu_after_stall", 0, ob[0][0], 0);
        check("lu_fwd2",        0, ob[0][4], 2);
        check("lu_stall_cnt",   0, ob[0][5], 1);
        advance();
        nops(4);
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        cycle();
        drive(1, 1, 1, 5, 0, 6, 1, 0, 0);
        @(negedge clk);
        check_model();
        check("lu_unused_stall", 0, ob[0][0], 0);
        advance();
        nops(4);

        // Full interlock: 2 stall cycles with WB bypass, 3 without.
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        cycle();
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_model();
            check("il_byp_stall",   1, ob[1][0], 32'(bexp[i]));
            check("il_nobyp_stall", 2, ob[2][0], 32'(cexp[i]));
            if (bexp[i] == 0) check("il_byp_fwd", 1, ob[1][3], 0);
            advance();
        end
        nops(4);

        // Taken branch with a load-use hazard present: flush wins, nothing issues.
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        cycle();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 1);
        @(negedge clk);
        check_model();
        check("br_flush",  0, ob[0][2], 1);
        check("br_stall",  0, ob[0][0], 0);
        check("br_bubble", 0, ob[0][1], 1);
        advance();
        drive(1, 6, 1, 0, 0, 8, 1, 0, 0);
        @(negedge clk);
        check_model();
        check("br_flush_cnt", 0, ob[0][6], 1);
        check("br_stall_cnt", 0, ob[0][5], 1);
        check("br_no_issue",  0, ob[0][3], 0);
        advance();
        nops(4);

        // Saturation of the 4-bit counter: 8 rounds of 3 stalls each.
        for (int r = 0; r < 8; r++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
            cycle();
            drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
            for (int i = 0; i < 4; i++) cycle();
        end
        @(negedge clk);
        check("sat_stall_cnt", 2, ob[2][5], 15);
        advance();

        // Randomized traffic over a small register set, with one async reset in the middle.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            if (i == 200) async_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
